// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: op encodings and FSM states.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_OR    = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_SLT   = 4'h4;
    localparam logic [3:0] OP_SLTU  = 4'h5;
    localparam logic [3:0] OP_ROT   = 4'h6;
    localparam logic [3:0] OP_MULT  = 4'h7;
    localparam logic [3:0] OP_MULTU = 4'h8;
    localparam logic [3:0] OP_DIV   = 4'h9;
    localparam logic [3:0] OP_DIVU  = 4'hA;
    localparam logic [3:0] OP_MTHI  = 4'hB;
    localparam logic [3:0] OP_MTLO  = 4'hC;
    localparam logic [3:0] OP_MFHI  = 4'hD;
    localparam logic [3:0] OP_MFLO  = 4'hE;
    // 4'hF is left undefined and completes with a zero result.

    // state  | meaning
    // IDLE   | waiting for a request, in_ready high
    // ROT    | rotating one bit per cycle
    // MDU    | multiply/divide iterations, WIDTH cycles
    // DONE   | result valid, waiting for out_ready
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROT  = 2'd1,
        S_MDU  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/seq_alu_div_iter.sv
// Restoring unsigned divider, one quotient bit per step. The caller samples
// quo_next/rem_next on the final step so the answer lands on that same edge.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quo_next,
    output logic [WIDTH-1:0] rem_next
);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   shifted;
    logic             ge;

    // One restoring step; a zero divisor naturally yields all-ones quotient.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        ge       = (shifted >= {1'b0, dvs_q});
        rem_next = ge ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
        quo_next = {quo_q[WIDTH-2:0], ge};
    end

    // Load operands on acceptance, then advance one bit per step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic, bit-serial rotate, and
// iterative multiply/divide writing the HI/LO pair.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             ovf
);

    import seq_alu_pkg::*;

    localparam logic [SHW:0] CNT_MDU = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

    state_e           state;
    logic [SHW:0]     cnt;
    logic [WIDTH-1:0] rot_val;
    logic             rot_left;
    logic             is_mul_q;
    logic             neg_q;
    logic             rem_neg_q;
    logic             div_zero_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;

    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     diff_ext;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   rot_n;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_n;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_next;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic               is_div_op;
    logic               div_load;
    logic               div_step;

    // Held low through reset so nothing is accepted until release.
    assign in_ready = (state == S_IDLE) && reset;

    // Single-cycle results and overflow from a sign-extended WIDTH+1 sum.
    always_comb begin
        sum_ext  = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        diff_ext = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        alu_res  = '0;
        alu_ovf  = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_ovf = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
            end
            OP_SUB: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_ovf = diff_ext[WIDTH] ^ diff_ext[WIDTH-1];
            end
            OP_OR:   alu_res = a | b;
            OP_AND:  alu_res = a & b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_MTHI: alu_res = a;
            OP_MTLO: alu_res = a;
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            default: alu_res = '0;
        endcase
    end

    // Operand magnitudes, rotate step, shift-add multiply step and sign fixups.
    always_comb begin
        abs_a    = a[WIDTH-1] ? -a : a;
        abs_b    = b[WIDTH-1] ? -b : b;
        rot_n    = rot_left ? {rot_val[WIDTH-2:0], rot_val[WIDTH-1]}
                            : {rot_val[0], rot_val[WIDTH-1:1]};
        mul_sum  = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        prod_n   = {mul_sum, mul_lo[WIDTH-1:1]};
        prod_fix = neg_q ? -prod_n : prod_n;
        q_fix    = neg_q ? -quo_next : quo_next;
        r_fix    = rem_neg_q ? -rem_next : rem_next;
    end

    assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);
    assign div_load  = (state == S_IDLE) && in_valid && is_div_op;
    assign div_step  = (state == S_MDU) && !is_mul_q;

    div_iter #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .reset    (reset),
        .load     (div_load),
        .step     (div_step),
        .dividend ((op == OP_DIV) ? abs_a : a),
        .divisor  ((op == OP_DIV) ? abs_b : b),
        .quo_next (quo_next),
        .rem_next (rem_next)
    );

    // Main FSM with registered result/hi/lo/ovf/out_valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            rot_val    <= '0;
            rot_left   <= 1'b0;
            is_mul_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            dvd_q      <= '0;
            mcand      <= '0;
            mul_hi     <= '0;
            mul_lo     <= '0;
            result     <= '0;
            hi         <= '0;
            lo         <= '0;
            ovf        <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (op == OP_ROT) begin
                            if (b[SHW-1:0] == '0) begin
                                result    <= a;
                                ovf       <= 1'b0;
                                out_valid <= 1'b1;
                                state     <= S_DONE;
                            end else begin
                                rot_val  <= a;
                                rot_left <= b[0];
                                cnt      <= {1'b0, b[SHW-1:0]};
                                state    <= S_ROT;
                            end
                        end else if (op == OP_MULT || op == OP_MULTU) begin
                            is_mul_q <= 1'b1;
                            mcand    <= (op == OP_MULT) ? abs_a : a;
                            mul_lo   <= (op == OP_MULT) ? abs_b : b;
                            mul_hi   <= '0;
                            neg_q    <= (op == OP_MULT) && (a[WIDTH-1] ^ b[WIDTH-1]);
                            cnt      <= CNT_MDU;
                            state    <= S_MDU;
                        end else if (is_div_op) begin
                            is_mul_q   <= 1'b0;
                            neg_q      <= (op == OP_DIV) && (a[WIDTH-1] ^ b[WIDTH-1]);
                            rem_neg_q  <= (op == OP_DIV) && a[WIDTH-1];
                            div_zero_q <= (b == '0);
                            dvd_q      <= a;
                            cnt        <= CNT_MDU;
                            state      <= S_MDU;
                        end else begin
                            if (op == OP_MTHI) hi <= a;
                            if (op == OP_MTLO) lo <= a;
                            result    <= alu_res;
                            ovf       <= alu_ovf;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_ROT: begin
                    rot_val <= rot_n;
                    cnt     <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        result    <= rot_n;
                        ovf       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_MDU: begin
                    cnt <= cnt - CNT_ONE;
                    if (is_mul_q) begin
                        mul_hi <= prod_n[2*WIDTH-1:WIDTH];
                        mul_lo <= prod_n[WIDTH-1:0];
                    end
                    if (cnt == CNT_ONE) begin
                        if (is_mul_q) begin
                            hi     <= prod_fix[2*WIDTH-1:WIDTH];
                            lo     <= prod_fix[WIDTH-1:0];
                            result <= prod_fix[WIDTH-1:0];
                        end else if (div_zero_q) begin
                            // Divide by zero bypasses sign fixup entirely.
                            hi     <= dvd_q;
                            lo     <= '1;
                            result <= '1;
                        end else begin
                            hi     <= r_fix;
                            lo     <= q_fix;
                            result <= q_fix;
                        end
                        ovf       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32.
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int LAT_MAX = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'h0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ovf;

    int n_cmp = 0;
    int n_bad = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .hi        (hi),
        .lo        (lo),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Offer one request from IDLE and count cycles until out_valid rises.
    task automatic run_op(input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] y, output int lat);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < LAT_MAX) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if ({in_ready, out_valid, ovf} !== 3'b000 || result !== 0 || hi !== 0 || lo !== 0) begin
            n_bad++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b ovf=%b result=%h hi=%h lo=%h, required all 0",
                     in_ready, out_valid, ovf, result, hi, lo);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        int lat;
        run_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, lat);
        n_cmp++;
        if (lat !== 1 || result !== 32'h8000_0000 || ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL add_ovf: lat=%0d result=%h ovf=%b required lat=1 result=80000000 ovf=1", lat, result, ovf);
        end
        take_result();
        run_op(OP_SUB, 32'h8000_0000, 32'h1, lat);
        n_cmp++;
        if (lat !== 1 || result !== 32'h7FFF_FFFF || ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL sub_ovf: lat=%0d result=%h ovf=%b required lat=1 result=7fffffff ovf=1", lat, result, ovf);
        end
        take_result();
        run_op(OP_ADD, 32'd5, 32'd3, lat);
        n_cmp++;
        if (result !== 32'd8 || ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL add_plain: result=%h ovf=%b required 8 ovf=0", result, ovf);
        end
        take_result();
        run_op(OP_OR, 32'hF0F0_0000, 32'h0000_0F0F, lat);
        n_cmp++;
        if (result !== 32'hF0F0_0F0F) begin
            n_bad++;
            $display("FAIL or: result=%h required f0f00f0f", result);
        end
        take_result();
        run_op(OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, lat);
        n_cmp++;
        if (result !== 32'h0F00_0F00) begin
            n_bad++;
            $display("FAIL and: result=%h required 0f000f00", result);
        end
        take_result();
        run_op(OP_SLT, 32'hFFFF_FFFF, 32'h1, lat);
        n_cmp++;
        if (result !== 32'h1) begin
            n_bad++;
            $display("FAIL slt: result=%h required 1", result);
        end
        take_result();
        run_op(OP_SLTU, 32'hFFFF_FFFF, 32'h1, lat);
        n_cmp++;
        if (result !== 32'h0) begin
            n_bad++;
            $display("FAIL sltu: result=%h required 0", result);
        end
        take_result();
    endtask

    task automatic test_rot();
        int lat;
        run_op(OP_ROT, 32'h1, 32'd3, lat);
        n_cmp++;
        if (lat !== 4 || result !== 32'h8) begin
            n_bad++;
            $display("FAIL rot_left3: lat=%0d result=%h required lat=4 result=00000008", lat, result);
        end
        take_result();
        run_op(OP_ROT, 32'h1, 32'd2, lat);
        n_cmp++;
        if (lat !== 3 || result !== 32'h4000_0000) begin
            n_bad++;
            $display("FAIL rot_right2: lat=%0d result=%h required lat=3 result=40000000", lat, result);
        end
        take_result();
        run_op(OP_ROT, 32'hDEAD_BEEF, 32'd0, lat);
        n_cmp++;
        if (lat !== 1 || result !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL rot_zero: lat=%0d result=%h required lat=1 result=deadbeef", lat, result);
        end
        take_result();
    endtask

    task automatic test_mdu();
        int lat;
        run_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        n_cmp++;
        if (lat !== 33 || hi !== 32'h0 || lo !== 32'h1 || result !== 32'h1) begin
            n_bad++;
            $display("FAIL mult: lat=%0d hi=%h lo=%h result=%h required lat=33 hi=0 lo=1 result=1", lat, hi, lo, result);
        end
        take_result();
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        n_cmp++;
        if (lat !== 33 || hi !== 32'hFFFF_FFFE || lo !== 32'h1) begin
            n_bad++;
            $display("FAIL multu: lat=%0d hi=%h lo=%h required lat=33 hi=fffffffe lo=1", lat, hi, lo);
        end
        take_result();
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, lat);
        n_cmp++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            n_bad++;
            $display("FAIL mult_neg: hi=%h lo=%h required hi=ffffffff lo=ffffffeb", hi, lo);
        end
        take_result();
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat);
        n_cmp++;
        if (lat !== 33 || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF || result !== 32'hFFFF_FFFD) begin
            n_bad++;
            $display("FAIL div_neg: lat=%0d lo=%h hi=%h result=%h required lat=33 lo=fffffffd hi=ffffffff result=fffffffd",
                     lat, lo, hi, result);
        end
        take_result();
        run_op(OP_DIVU, 32'd100, 32'd7, lat);
        n_cmp++;
        if (lo !== 32'd14 || hi !== 32'd2) begin
            n_bad++;
            $display("FAIL divu: lo=%h hi=%h required lo=e hi=2", lo, hi);
        end
        take_result();
        run_op(OP_DIVU, 32'h1234_5678, 32'd0, lat);
        n_cmp++;
        if (lat !== 33 || lo !== 32'hFFFF_FFFF || hi !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL divu_zero: lat=%0d lo=%h hi=%h required lat=33 lo=ffffffff hi=12345678", lat, lo, hi);
        end
        take_result();
    endtask

    task automatic test_hilo();
        int lat;
        run_op(OP_MTHI, 32'hAAAA_0000, 32'h0, lat);
        n_cmp++;
        if (hi !== 32'hAAAA_0000 || result !== 32'hAAAA_0000 || lo !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL mthi: hi=%h result=%h lo=%h required hi=aaaa0000 result=aaaa0000 lo=ffffffff", hi, result, lo);
        end
        take_result();
        run_op(OP_MTLO, 32'h0000_5555, 32'h0, lat);
        n_cmp++;
        if (lo !== 32'h0000_5555 || hi !== 32'hAAAA_0000) begin
            n_bad++;
            $display("FAIL mtlo: lo=%h hi=%h required lo=00005555 hi=aaaa0000", lo, hi);
        end
        take_result();
        run_op(OP_MFHI, 32'h1, 32'h2, lat);
        n_cmp++;
        if (result !== 32'hAAAA_0000) begin
            n_bad++;
            $display("FAIL mfhi: result=%h required aaaa0000", result);
        end
        take_result();
        run_op(OP_MFLO, 32'h1, 32'h2, lat);
        n_cmp++;
        if (result !== 32'h0000_5555) begin
            n_bad++;
            $display("FAIL mflo: result=%h required 00005555", result);
        end
        take_result();
        run_op(OP_ADD, 32'h7FFF_FFFF, 32'h7FFF_FFFF, lat);
        take_result();
        run_op(4'hF, 32'h1234, 32'h5678, lat);
        n_cmp++;
        if (lat !== 1 || result !== 32'h0 || ovf !== 1'b0 || hi !== 32'hAAAA_0000 || lo !== 32'h0000_5555) begin
            n_bad++;
            $display("FAIL undef_op: lat=%0d result=%h ovf=%b hi=%h lo=%h required lat=1 result=0 ovf=0 hi=aaaa0000 lo=00005555",
                     lat, result, ovf, hi, lo);
        end
        take_result();
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(OP_ADD, 32'd1, 32'd2, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || result !== 32'd3 || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL done_hold[%0d]: out_valid=%b result=%h in_ready=%b required 1/3/0",
                         i, out_valid, result, in_ready);
            end
        end
        out_ready = 1'b1;
        in_valid = 1'b1; op = OP_ADD; a = 32'd10; b = 32'd20;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL no_accept_in_done: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || result !== 32'd30) begin
            n_bad++;
            $display("FAIL accept_next: out_valid=%b result=%h required 1/1e", out_valid, result);
        end
        take_result();
    endtask

    task automatic test_reset_mid_mdu();
        int lat;
        op = OP_DIVU; a = 32'hFFFF_0000; b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, ovf} !== 3'b000 || result !== 0 || hi !== 0 || lo !== 0) begin
            n_bad++;
            $display("FAIL reset_mid_mdu: in_ready=%b out_valid=%b ovf=%b result=%h hi=%h lo=%h required all 0",
                     in_ready, out_valid, ovf, result, hi, lo);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || hi !== 0 || lo !== 0) begin
            n_bad++;
            $display("FAIL reset_mid_release: in_ready=%b hi=%h lo=%h required 1/0/0", in_ready, hi, lo);
        end
        repeat (40) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL abandoned_op: out_valid=%b required 0", out_valid);
        end
        run_op(OP_ADD, 32'd2, 32'd2, lat);
        n_cmp++;
        if (lat !== 1 || result !== 32'd4) begin
            n_bad++;
            $display("FAIL after_reset_add: lat=%0d result=%h required 1/4", lat, result);
        end
        take_result();
    endtask

    initial begin
        test_reset();
        test_arith();
        test_rot();
        test_mdu();
        test_hilo();
        test_back_to_back();
        test_reset_mid_mdu();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, 32, datapath width in bits; SHALL be a power of two, 8 to 64.
REQ-002 Parameter SHW, $clog2(WIDTH), rotate-amount field width.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  operation request.
REQ-006 in_ready  out  1  block can accept a request.
REQ-007 op  in  4  operation code.
REQ-008 a  in  WIDTH  operand A.
REQ-009 b  in  WIDTH  operand B.
REQ-010 out_valid  out  1  result available.
REQ-011 out_ready  in  1  consumer takes the result.
REQ-012 result  out  WIDTH  operation result.
REQ-013 hi  out  WIDTH  HI register.
REQ-014 lo  out  WIDTH  LO register.
REQ-015 ovf  out  1  signed overflow of ADD/SUB; 0 for every other op.

Function
REQ-016 A request SHALL be accepted on a cycle where in_valid and in_ready are both 1; operands and op are captured at that edge.
REQ-017 The FSM SHALL have states IDLE, ROT, MDU, DONE; in_ready SHALL be 1 only in IDLE.
REQ-018 ADD, SUB, OR, AND, SLT (signed), SLTU, MTHI, MTLO, MFHI, MFLO SHALL go IDLE->DONE, giving out_valid 1 cycle after acceptance.
REQ-019 ovf SHALL be computed on a WIDTH+1-bit sign-extended sum/difference as XOR of its top two bits; result is the low WIDTH bits (wraps).
REQ-020 SLT/SLTU SHALL return zero-extended 1 or 0.
REQ-021 ROT: amount n = b[SHW-1:0]; b[0]=0 rotates right, b[0]=1 rotates left, true rotation (bit leaving one end re-enters the other); one bit per cycle in ROT, then DONE.
REQ-022 ROT with n=0 SHALL skip ROT, go to DONE, return a unchanged; latency n+1 cycles.
REQ-023 MULT/MULTU SHALL produce the 2*WIDTH-bit product into {hi,lo}; DIV/DIVU SHALL produce quotient in lo and remainder in hi; all four spend exactly WIDTH cycles in MDU, latency WIDTH+1; result = lo.
REQ-024 Signed divide: quotient truncates toward zero, remainder takes dividend sign.
REQ-025 Divide by zero SHALL give lo = all ones, hi = dividend; no flag raised.
REQ-026 MTHI/MTLO SHALL write a into hi/lo and return a; MFHI/MFLO return hi/lo unchanged.
REQ-027 DONE SHALL hold out_valid, result, ovf stable until out_ready=1, then return to IDLE next edge; a request offered in that same cycle SHALL NOT be accepted.
REQ-028 Undefined op codes SHALL complete in 1 cycle with result 0, ovf 0, hi/lo untouched.
REQ-029 hi/lo SHALL change only at MDU completion or MTHI/MTLO acceptance.

Reset
REQ-030 Assertion of reset at any time, including mid-ROT or mid-MDU, SHALL force IDLE, abandon the operation, and clear result, hi, lo, ovf, out_valid to 0 without waiting for clk.
REQ-031 in_ready SHALL be 0 while reset is low and 1 on the first cycle after release.

Structure
REQ-032 Package seq_alu_pkg SHALL hold the op encodings and the FSM state enum.
REQ-033 Sub-module div_iter SHALL implement the WIDTH-step restoring unsigned divider; sign handling stays in seq_alu.
REQ-034 The multiplier SHALL be a shift-add iterative loop inside seq_alu; no inferred wide multiplier.

Verification (WIDTH=32)
REQ-035 ADD a=0x7FFFFFFF b=1 -> result 0x80000000, ovf 1, out_valid 1 cycle after acceptance.
REQ-036 ROT a=0x00000001 b=3 -> 0x00000008 after 4 cycles; b=2 -> 0x40000000 after 3 cycles; b=0 -> a after 1 cycle.
REQ-037 DIV a=-7 b=2 -> lo 0xFFFFFFFD, hi 0xFFFFFFFF after 33 cycles; DIVU b=0 -> lo 0xFFFFFFFF, hi=a.
REQ-038 MULT a=0xFFFFFFFF b=0xFFFFFFFF -> hi 0, lo 1; MULTU same operands -> hi 0xFFFFFFFE, lo 1.
REQ-039 Hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready 0; pulse out_ready with in_valid=1 -> request accepted only next cycle.
REQ-040 Assert reset at MDU cycle 10 -> all outputs 0 immediately, in_ready 1 after release, hi/lo 0.
